// File: rtl/alu_share_pkg.sv
// Shared types for the ALU-sharing arbiter: opcodes, arbiter states and the
// tag that follows each issued operation through the ALU latency.
package alu_share_pkg;

   localparam int MAX_NREQ = 8;
   localparam int SLOT_W   = $clog2(MAX_NREQ);

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SHL  = 4'd5,
      OP_SHR  = 4'd6,
      OP_PASS = 4'd7
   } alu_op_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } arb_state_e;

   // Slot field is sized for the largest supported requester count.
   typedef struct packed {
      logic              valid;
      logic [SLOT_W-1:0] slot;
   } tag_t;

   function automatic logic [MAX_NREQ-1:0] slot_onehot(input logic [SLOT_W-1:0] slot);
      return MAX_NREQ'(1) << slot;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// searching upward and wrapping from N-1 back to 0.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 3
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] index,
   output logic          any
);

   logic [IW:0]  pos;
   logic [N-1:0] mask;

   // Scan offsets from the far end down so the smallest offset from ptr wins.
   always_comb begin
      grant = '0;
      index = '0;
      any   = 1'b0;
      pos   = '0;
      mask  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         pos = {1'b0, ptr} + (IW+1)'(k);
         if (pos >= (IW+1)'(N)) begin
            pos = pos - (IW+1)'(N);
         end
         mask = N'(1) << pos;
         if ((req & mask) != '0) begin
            grant = mask;
            index = pos[IW-1:0];
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among NREQ requesters with round-robin issue and a tag pipeline
// that routes each result back to its originator. Define ALU_ARB_LOCK_EN for the lock input.
module alu_share_arbiter
   import alu_share_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int W       = 4,
   parameter int ALU_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   input  logic [NREQ*4-1:0] req_op,
   input  logic              hold,
`ifdef ALU_ARB_LOCK_EN
   input  logic              lock,
`endif
   output logic [W-1:0]      alu_a,
   output logic [W-1:0]      alu_b,
   output logic [3:0]        alu_op,
   input  logic [W-1:0]      alu_out,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [W-1:0]      rsp_data,
   output logic              busy
);

   arb_state_e        state;
   logic [SLOT_W-1:0] ptr;
   logic [SLOT_W-1:0] ptr_inc;
   logic [SLOT_W-1:0] ptr_after;
   logic [NREQ-1:0]   pick_grant;
   logic [SLOT_W-1:0] pick_index;
   logic              pick_any;
   logic              grant_en;
   logic              xfer;
   logic [W-1:0]      sel_a;
   logic [W-1:0]      sel_b;
   logic [3:0]        sel_op;
   logic              inflight_any;
   tag_t              tag_pipe [ALU_LAT];

   rr_pick #(
      .N  (NREQ),
      .IW (SLOT_W)
   ) u_pick (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (pick_grant),
      .index (pick_index),
      .any   (pick_any)
   );

   // hold gates grants in the same cycle it is seen, before the state catches up.
   assign grant_en  = (state == ST_RUN) && !hold && !rst;
   assign req_ready = grant_en ? pick_grant : '0;
   assign xfer      = grant_en && pick_any;

   assign ptr_inc = (pick_index == SLOT_W'(NREQ - 1)) ? '0 : pick_index + SLOT_W'(1);

`ifdef ALU_ARB_LOCK_EN
   // A locked transfer parks the pointer on the winner so it keeps priority.
   assign ptr_after = lock ? pick_index : ptr_inc;
`else
   assign ptr_after = ptr_inc;
`endif

   always_comb begin
      sel_a  = W'(req_a >> (int'(pick_index) * W));
      sel_b  = W'(req_b >> (int'(pick_index) * W));
      sel_op = 4'(req_op >> (int'(pick_index) * 4));
   end

   // Control state, arbitration pointer and operand launch registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_RUN;
         ptr    <= '0;
         alu_a  <= '0;
         alu_b  <= '0;
         alu_op <= '0;
      end else begin
         case (state)
            ST_RUN:  if (hold)  state <= ST_HOLD;
            ST_HOLD: if (!hold) state <= ST_RUN;
            default: state <= ST_RUN;
         endcase
         if (xfer) begin
            ptr    <= ptr_after;
            alu_a  <= sel_a;
            alu_b  <= sel_b;
            alu_op <= sel_op;
         end
      end
   end

   // Tags ride alongside the ALU pipeline; the last stage lines up with alu_out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < ALU_LAT; s++) begin
            tag_pipe[s] <= '0;
         end
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else begin
         tag_pipe[0] <= '{valid: xfer, slot: (xfer ? pick_index : '0)};
         for (int s = 1; s < ALU_LAT; s++) begin
            tag_pipe[s] <= tag_pipe[s-1];
         end
         if (tag_pipe[ALU_LAT-1].valid) begin
            rsp_valid <= NREQ'(slot_onehot(tag_pipe[ALU_LAT-1].slot));
            rsp_data  <= alu_out;
         end else begin
            rsp_valid <= '0;
         end
      end
   end

   always_comb begin
      inflight_any = 1'b0;
      for (int s = 0; s < ALU_LAT; s++) begin
         inflight_any = inflight_any | tag_pipe[s].valid;
      end
   end

   assign busy = inflight_any | (|rsp_valid);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: behavioural model checked every cycle
// plus directed scenarios with literal expectations. Build with ALU_ARB_LOCK_EN for the lock test.
module tb_alu_share_arbiter;

   localparam int NREQ    = 4;
   localparam int W       = 4;
   localparam int ALU_LAT = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              hold = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a = '0;
   logic [NREQ*W-1:0] req_b = '0;
   logic [NREQ*4-1:0] req_op = '0;
   logic [W-1:0]      alu_a;
   logic [W-1:0]      alu_b;
   logic [3:0]        alu_op;
   logic [W-1:0]      alu_out;
   logic [NREQ-1:0]   rsp_valid;
   logic [W-1:0]      rsp_data;
   logic              busy;
`ifdef ALU_ARB_LOCK_EN
   logic              lock = 1'b0;
`endif

   typedef struct {
      int         slot;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [3:0] op;
   } req_t;

   typedef struct {
      int         due;
      int         slot;
      logic [W-1:0] data;
   } flight_t;

   typedef struct {
      int cyc;
      int slot;
      int data;
   } ev_t;

   req_t    pend[$];
   flight_t inflight[$];
   ev_t     grant_log[$];
   ev_t     rsp_log[$];

   int n_compared = 0;
   int n_failed   = 0;
   int cyc        = 0;

   alu_share_arbiter #(
      .NREQ    (NREQ),
      .W       (W),
      .ALU_LAT (ALU_LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .hold      (hold),
`ifdef ALU_ARB_LOCK_EN
      .lock      (lock),
`endif
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_out   (alu_out),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] op);
      case (op)
         4'd0:    alu_fn = a + b;
         4'd1:    alu_fn = a - b;
         4'd2:    alu_fn = a & b;
         4'd3:    alu_fn = a | b;
         4'd4:    alu_fn = a ^ b;
         4'd5:    alu_fn = a << b;
         4'd6:    alu_fn = a >> b;
         default: alu_fn = a;
      endcase
   endfunction

   // Environment ALU: one register stage after the launch registers.
   logic [W-1:0] alu_pipe;
   always @(posedge clk) alu_pipe <= alu_fn(alu_a, alu_b, alu_op);
   assign alu_out = alu_pipe;

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_compared++;
      if (actual != expected) begin
         n_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic add_req(input int slot, input int a, input int b, input int op);
      req_t r;
      r.slot = slot;
      r.a    = W'(a);
      r.b    = W'(b);
      r.op   = 4'(op);
      pend.push_back(r);
   endtask

   task automatic drive_pending();
      logic [NREQ-1:0] v;
      bit found;
      v = '0;
      for (int s = 0; s < NREQ; s++) begin
         found = 1'b0;
         for (int j = 0; j < pend.size(); j++) begin
            if (!found && pend[j].slot == s) begin
               req_a[s*W +: W]  = pend[j].a;
               req_b[s*W +: W]  = pend[j].b;
               req_op[s*4 +: 4] = pend[j].op;
               v[s]  = 1'b1;
               found = 1'b1;
            end
         end
      end
      req_valid = v;
   endtask

   task automatic pop_slot(input int slot);
      bit done;
      done = 1'b0;
      for (int j = 0; j < pend.size(); j++) begin
         if (!done && pend[j].slot == slot) begin
            pend.delete(j);
            done = 1'b1;
         end
      end
   endtask

   // Runs n cycles, retiring each slot's head request once it transfers.
   task automatic applyStimulus(input int n);
      logic [NREQ-1:0] xf;
      int gcyc;
      ev_t e;
      drive_pending();
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         xf   = req_valid & req_ready;
         gcyc = cyc;
         @(posedge clk);
         #1;
         for (int s = 0; s < NREQ; s++) begin
            if (xf[s]) begin
               e.cyc  = gcyc;
               e.slot = s;
               e.data = 0;
               grant_log.push_back(e);
               pop_slot(s);
            end
         end
         drive_pending();
      end
   endtask

   task automatic doReset();
      pend.delete();
      drive_pending();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic clear_logs();
      grant_log.delete();
      rsp_log.delete();
   endtask

   // Reference model: per-cycle expectations from the arbitration rules.
   int           m_ptr = 0;
   bit           m_hold_state = 1'b0;
   logic [W-1:0] m_alu_a = '0;
   logic [W-1:0] m_alu_b = '0;
   logic [3:0]   m_alu_op = '0;

   initial begin : compare
      logic [NREQ-1:0] exp_ready;
      logic [NREQ-1:0] exp_rsp;
      logic [W-1:0]    exp_data;
      logic [W-1:0]    ga;
      logic [W-1:0]    gb;
      logic [3:0]      gop;
      int              granted;
      int              idx;
      int              act_slot;
      flight_t         f;
      ev_t             e;
      forever begin
         @(negedge clk);
         if (rst) begin
            inflight.delete();
            m_ptr        = 0;
            m_hold_state = 1'b0;
            m_alu_a      = '0;
            m_alu_b      = '0;
            m_alu_op     = '0;
            checkOutput("rst_req_ready", int'(req_ready), 0);
            checkOutput("rst_rsp_valid", int'(rsp_valid), 0);
            checkOutput("rst_rsp_data", int'(rsp_data), 0);
            checkOutput("rst_alu_a", int'(alu_a), 0);
            checkOutput("rst_alu_op", int'(alu_op), 0);
            checkOutput("rst_busy", int'(busy), 0);
         end else begin
            while (inflight.size() > 0 && inflight[0].due < cyc) void'(inflight.pop_front());
            exp_rsp  = '0;
            exp_data = '0;
            if (inflight.size() > 0 && inflight[0].due == cyc) begin
               exp_rsp  = NREQ'(1) << inflight[0].slot;
               exp_data = inflight[0].data;
            end
            checkOutput("rsp_valid", int'(rsp_valid), int'(exp_rsp));
            if (exp_rsp != '0) checkOutput("rsp_data", int'(rsp_data), int'(exp_data));
            checkOutput("busy", int'(busy), (inflight.size() > 0) ? 1 : 0);
            checkOutput("alu_a", int'(alu_a), int'(m_alu_a));
            checkOutput("alu_b", int'(alu_b), int'(m_alu_b));
            checkOutput("alu_op", int'(alu_op), int'(m_alu_op));

            if (rsp_valid != '0) begin
               act_slot = -1;
               for (int s = 0; s < NREQ; s++) if (rsp_valid == (NREQ'(1) << s)) act_slot = s;
               e.cyc  = cyc;
               e.slot = act_slot;
               e.data = int'(rsp_data);
               rsp_log.push_back(e);
            end

            granted = -1;
            if (!m_hold_state && !hold) begin
               for (int k = 0; k < NREQ; k++) begin
                  idx = (m_ptr + k) % NREQ;
                  if (granted < 0 && ((req_valid >> idx) & NREQ'(1)) != '0) granted = idx;
               end
            end
            exp_ready = (granted >= 0) ? (NREQ'(1) << granted) : '0;
            checkOutput("req_ready", int'(req_ready), int'(exp_ready));

            if (granted >= 0) begin
               ga  = W'(req_a >> (granted * W));
               gb  = W'(req_b >> (granted * W));
               gop = 4'(req_op >> (granted * 4));
               f.due  = cyc + ALU_LAT + 1;
               f.slot = granted;
               f.data = alu_fn(ga, gb, gop);
               inflight.push_back(f);
               m_alu_a  = ga;
               m_alu_b  = gb;
               m_alu_op = gop;
               m_ptr    = (granted + 1) % NREQ;
`ifdef ALU_ARB_LOCK_EN
               if (lock) m_ptr = granted;
`endif
            end
            m_hold_state = hold;
         end
      end
   end

   initial begin : main
      int start_cyc;
      int release_cyc;
      $display("[TB] start");
      doReset();

      // Single request on slot 2: 3 + 4
      clear_logs();
      add_req(2, 3, 4, 0);
      start_cyc = cyc;
      applyStimulus(6);
      checkOutput("t1_grant_count", grant_log.size(), 1);
      if (grant_log.size() == 1) begin
         checkOutput("t1_grant_slot", grant_log[0].slot, 2);
         checkOutput("t1_grant_same_cycle", grant_log[0].cyc, start_cyc);
      end
      checkOutput("t1_rsp_count", rsp_log.size(), 1);
      if (rsp_log.size() == 1 && grant_log.size() == 1) begin
         checkOutput("t1_rsp_slot", rsp_log[0].slot, 2);
         checkOutput("t1_rsp_data", rsp_log[0].data, 7);
         checkOutput("t1_latency", rsp_log[0].cyc - grant_log[0].cyc, ALU_LAT + 1);
      end

      // All slots busy: strict rotation
      doReset();
      clear_logs();
      for (int s = 0; s < NREQ; s++) begin
         add_req(s, s + 1, 2, 0);
         add_req(s, s + 5, 3, 1);
      end
      applyStimulus(12);
      checkOutput("t2_grant_count", grant_log.size(), 8);
      checkOutput("t2_rsp_count", rsp_log.size(), 8);
      if (grant_log.size() == 8 && rsp_log.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            checkOutput("t2_grant_order", grant_log[i].slot, i % NREQ);
            checkOutput("t2_grant_cycle", grant_log[i].cyc - grant_log[0].cyc, i);
            checkOutput("t2_rsp_order", rsp_log[i].slot, i % NREQ);
         end
         checkOutput("t2_first_data", rsp_log[0].data, 3);
         checkOutput("t2_last_data", rsp_log[7].data, 5);
      end

      // hold with two in flight, then release
      clear_logs();
      add_req(0, 1, 1, 0);
      add_req(0, 2, 2, 0);
      add_req(1, 3, 3, 0);
      add_req(1, 4, 4, 0);
      applyStimulus(2);
      hold = 1'b1;
      applyStimulus(5);
      checkOutput("t3_no_grant_in_hold", grant_log.size(), 2);
      checkOutput("t3_drained_rsp", rsp_log.size(), 2);
      checkOutput("t3_busy_low", int'(busy), 0);
      checkOutput("t3_ready_blocked", int'(req_ready), 0);
      hold = 1'b0;
      release_cyc = cyc;
      applyStimulus(8);
      checkOutput("t3_total_grants", grant_log.size(), 4);
      if (grant_log.size() == 4) begin
         checkOutput("t3_resume_slot", grant_log[2].slot, 0);
         checkOutput("t3_resume_cycle", grant_log[2].cyc, release_cyc + 1);
         checkOutput("t3_next_slot", grant_log[3].slot, 1);
      end

      // Reset right after issuing 15 + 1
      clear_logs();
      add_req(2, 15, 1, 0);
      applyStimulus(1);
      rst = 1'b1;
      #1;
      checkOutput("t4_ready_zero", int'(req_ready), 0);
      checkOutput("t4_rsp_zero", int'(rsp_valid), 0);
      checkOutput("t4_alu_a_zero", int'(alu_a), 0);
      checkOutput("t4_busy_zero", int'(busy), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(6);
      checkOutput("t4_no_rsp_after_reset", rsp_log.size(), 0);
      clear_logs();
      add_req(3, 1, 1, 0);
      add_req(0, 2, 1, 0);
      applyStimulus(6);
      if (grant_log.size() > 0) checkOutput("t4_first_grant", grant_log[0].slot, 0);
      checkOutput("t4_grant_count", grant_log.size(), 2);

      // Slot 3 back-to-back with ALU wrap
      clear_logs();
      add_req(3, 15, 1, 0);
      add_req(3, 2, 3, 0);
      add_req(3, 7, 2, 1);
      add_req(3, 9, 6, 4);
      applyStimulus(8);
      checkOutput("t5_grant_count", grant_log.size(), 4);
      checkOutput("t5_rsp_count", rsp_log.size(), 4);
      if (grant_log.size() == 4 && rsp_log.size() == 4) begin
         checkOutput("t5_consecutive", grant_log[3].cyc - grant_log[0].cyc, 3);
         checkOutput("t5_rsp_slot", rsp_log[0].slot, 3);
         checkOutput("t5_wrap_data", rsp_log[0].data, 0);
         checkOutput("t5_data1", rsp_log[1].data, 5);
         checkOutput("t5_data2", rsp_log[2].data, 5);
         checkOutput("t5_data3", rsp_log[3].data, 15);
         checkOutput("t5_rsp_consecutive", rsp_log[3].cyc - rsp_log[0].cyc, 3);
      end

`ifdef ALU_ARB_LOCK_EN
      // Slot 1 locks for three transfers while slot 2 waits
      clear_logs();
      lock = 1'b1;
      add_req(1, 1, 1, 0);
      add_req(1, 2, 1, 0);
      add_req(1, 3, 1, 0);
      add_req(2, 8, 8, 3);
      applyStimulus(4);
      lock = 1'b0;
      applyStimulus(4);
      checkOutput("t6_grant_count", grant_log.size(), 4);
      if (grant_log.size() == 4) begin
         checkOutput("t6_g0", grant_log[0].slot, 1);
         checkOutput("t6_g1", grant_log[1].slot, 1);
         checkOutput("t6_g2", grant_log[2].slot, 1);
         checkOutput("t6_g3", grant_log[3].slot, 2);
      end
`endif

      applyStimulus(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
      $finish;
   end

endmodule
